// File: rtl/chasy_mode_ctrl.sv
// Front-panel controller for the clock/timer/stopwatch datapath: button conditioning,
// mode selection, field-by-field time setup, run/stop control and expiry alarm.
module chasy_mode_ctrl #(
    parameter int DEB_CYCLES   = 500000,
    parameter int ALARM_CYCLES = 250000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  button,
    input  logic [23:0] cur_time,
    input  logic        expired,
    output logic [1:0]  rezhim,
    output logic [1:0]  setup_field,
    output logic [23:0] setup_data,
    output logic        load_pulse,
    output logic        run_en,
    output logic [3:0]  led
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SET_SEC, SET_MIN, SET_HOUR, COMMIT, ALARM
    } state_t;

    logic [3:0]          sync0_q, sync1_q, level_q, level_d, press_q, press_d;
    logic [3:0][DW-1:0]  deb_cnt_q, deb_cnt_d;

    state_t              state_q, state_d;
    logic [1:0]          rezhim_q, rezhim_d;
    logic [1:0]          field_q, field_d;
    logic [23:0]         data_q, data_d;
    logic                load_q, load_d;
    logic                run_q, run_d;
    logic [3:0]          led_q, led_d;
    logic [AW-1:0]       alarm_cnt_q, alarm_cnt_d;

    logic ev_setup, ev_inc, ev_start, ev_mode, ev_any;

    function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max);
        return (v >= max) ? 8'd0 : v + 8'd1;
    endfunction

    // Accepted level follows the synced level only after it has differed for DEB_CYCLES cycles.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        level_d   = level_q;
        press_d   = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync1_q[i] == level_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                deb_cnt_d[i] = '0;
                level_d[i]   = sync1_q[i];
                press_d[i]   = sync1_q[i];
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync0_q   <= '0;
            sync1_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            deb_cnt_q <= '0;
        end else begin
            sync0_q   <= button;
            sync1_q   <= sync0_q;
            level_q   <= level_d;
            press_q   <= press_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // One winner per cycle: setup > increment > start/stop > mode.
    assign ev_setup = press_q[2];
    assign ev_inc   = press_q[1] & ~press_q[2];
    assign ev_start = press_q[3] & ~press_q[2] & ~press_q[1];
    assign ev_mode  = press_q[0] & ~(|press_q[3:1]);
    assign ev_any   = |press_q;

    always_comb begin
        state_d     = state_q;
        rezhim_d    = rezhim_q;
        field_d     = field_q;
        data_d      = data_q;
        load_d      = 1'b0;
        run_d       = run_q;
        led_d       = led_q;
        alarm_cnt_d = alarm_cnt_q;
        case (state_q)
            IDLE: begin
                // A running timer hitting zero takes precedence over any button this cycle.
                if (rezhim_q == 2'd1 && run_q && expired) begin
                    state_d     = ALARM;
                    run_d       = 1'b0;
                    led_d       = 4'hF;
                    alarm_cnt_d = '0;
                end else if (ev_setup) begin
                    if (rezhim_q != 2'd2) begin
                        data_d  = cur_time;
                        state_d = SET_SEC;
                        field_d = 2'd1;
                        run_d   = 1'b0;
                    end
                end else if (ev_start) begin
                    if (rezhim_q == 2'd2)
                        run_d = ~run_q;
                    else if (rezhim_q == 2'd1)
                        run_d = run_q ? 1'b0 : (cur_time != 24'd0);
                end else if (ev_mode) begin
                    rezhim_d = (rezhim_q == 2'd2) ? 2'd0 : rezhim_q + 2'd1;
                    run_d    = 1'b0;
                end
            end
            SET_SEC: begin
                if (ev_setup) begin
                    state_d = SET_MIN;
                    field_d = 2'd2;
                end else if (ev_inc) begin
                    data_d[7:0] = wrap_inc(data_q[7:0], 8'd59);
                end
            end
            SET_MIN: begin
                if (ev_setup) begin
                    state_d = SET_HOUR;
                    field_d = 2'd3;
                end else if (ev_inc) begin
                    data_d[15:8] = wrap_inc(data_q[15:8], 8'd59);
                end
            end
            SET_HOUR: begin
                if (ev_setup) begin
                    state_d = COMMIT;
                    field_d = 2'd0;
                    load_d  = 1'b1;
                end else if (ev_inc) begin
                    data_d[23:16] = wrap_inc(data_q[23:16], 8'd23);
                end
            end
            COMMIT: state_d = IDLE;
            ALARM: begin
                if (ev_any || alarm_cnt_q == ALARM_LAST) begin
                    state_d     = IDLE;
                    led_d       = 4'h0;
                    alarm_cnt_d = '0;
                end else begin
                    alarm_cnt_d = alarm_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rezhim_q    <= 2'd0;
            field_q     <= 2'd0;
            data_q      <= 24'd0;
            load_q      <= 1'b0;
            run_q       <= 1'b0;
            led_q       <= 4'h0;
            alarm_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rezhim_q    <= rezhim_d;
            field_q     <= field_d;
            data_q      <= data_d;
            load_q      <= load_d;
            run_q       <= run_d;
            led_q       <= led_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    assign rezhim      = rezhim_q;
    assign setup_field = field_q;
    assign setup_data  = data_q;
    assign load_pulse  = load_q;
    assign run_en      = run_q;
    assign led         = led_q;

endmodule
